// File: rtl/rx_rcst_ctrl.sv
// rx_rcst_ctrl: receive frame sequencer for the frame-reconstruct datapath.
// Tracks XGMII frame boundaries, emits the SFD pulse, latches the per-frame
// embed/CRC-replace decision and reports frame end, length and errors.
// Optional statistics counters are built when RX_RCST_STAT_EN is defined.
module rx_rcst_ctrl #(
  parameter int unsigned MAX_BYTES = 1536,
  parameter int unsigned MIN_BYTES = 64
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_clk_en_i,
  input  logic [31:0] tsu_cfg_i,
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  input  logic        ptp_info_vld_i,
  input  logic        is_ptp_message_i,
  input  logic [3:0]  ptp_messageType_i,
  output logic        get_sfd_pulse_o,
  output logic        frame_active_o,
  output logic        rpl_crc_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [13:0] byte_len_o
`ifdef RX_RCST_STAT_EN
  ,
  input  logic        stat_clr_i,
  output logic [31:0] rx_frm_cnt_o,
  output logic [31:0] rx_emb_cnt_o,
  output logic [15:0] rx_err_cnt_o
`endif
);

  localparam int unsigned CNT_W = 14;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_SFD   = 8'hD5;
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_PRE4, S_DATA, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt, fin;
  logic             sfd_nxt, active_nxt, done_nxt, err_nxt, rpl_nxt;
  logic [CNT_W-1:0] len_nxt;

  logic             has_ctl, term_any, all_idle, start0, start4, embed;
  logic [2:0]       first_lane;
  logic [7:0]       first_char;
  logic             unused_cfg;

  // Saturating add of a small increment onto the byte counter
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign unused_cfg = ^{tsu_cfg_i[31:6], tsu_cfg_i[4:0], ptp_messageType_i[2:0]};

  // Decode control characters of the current word; lowest control lane wins
  always_comb begin
    has_ctl    = |rxc_i;
    first_lane = '0;
    for (int n = 7; n >= 0; n--) begin
      if (rxc_i[n]) first_lane = 3'(n);
    end
    first_char = rxd_i[8*first_lane +: 8];
    term_any   = 1'b0;
    all_idle   = &rxc_i;
    for (int n = 0; n < 8; n++) begin
      if (rxc_i[n] && (rxd_i[8*n +: 8] == C_TERM)) term_any = 1'b1;
      if (rxd_i[8*n +: 8] != C_IDLE) all_idle = 1'b0;
    end
    start0 = rxc_i[0] && (rxd_i[7:0] == C_START);
    start4 = rxc_i[4] && (rxd_i[39:32] == C_START);
    embed  = tsu_cfg_i[5] & is_ptp_message_i & ~ptp_messageType_i[3];
  end

  // Next-state, counter and output decisions
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = byte_cnt;
    fin        = '0;
    sfd_nxt    = 1'b0;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    len_nxt    = byte_len_o;
    rpl_nxt    = rpl_crc_o;
    case (state)
      S_IDLE: begin
        if (start0) begin
          state_nxt  = S_DATA;
          sfd_nxt    = 1'b1;
          active_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (start4) begin
          state_nxt = S_PRE4;
        end
      end
      S_PRE4: begin
        if ((rxc_i == 8'h00) && (rxd_i[31:24] == C_SFD)) begin
          state_nxt  = S_DATA;
          sfd_nxt    = 1'b1;
          active_nxt = 1'b1;
          cnt_nxt    = CNT_W'(4);
        end else begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_DATA: begin
        if (!has_ctl) begin
          cnt_nxt    = sat_add(byte_cnt, 4'd8);
          active_nxt = 1'b1;
        end else if (first_char == C_TERM) begin
          fin        = sat_add(byte_cnt, {1'b0, first_lane});
          cnt_nxt    = fin;
          len_nxt    = fin;
          active_nxt = 1'b1;
          if ((fin < MIN_L) || (fin > MAX_L)) err_nxt = 1'b1;
          else done_nxt = 1'b1;
          // A Start in lane 4 behind an early Terminate opens the next frame
          if (start4 && (first_lane < 3'd4)) state_nxt = S_PRE4;
          else state_nxt = S_IDLE;
        end else if ((first_lane == 3'd0) && (first_char == C_START)) begin
          err_nxt    = 1'b1;
          sfd_nxt    = 1'b1;
          active_nxt = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_DATA;
        end else if ((first_lane == 3'd4) && (first_char == C_START)) begin
          err_nxt   = 1'b1;
          state_nxt = S_PRE4;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (term_any || all_idle) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (sfd_nxt) rpl_nxt = 1'b0;
    else if (err_nxt) rpl_nxt = 1'b0;
    else if ((state == S_DATA) && ptp_info_vld_i && embed) rpl_nxt = 1'b1;
  end

  // State and registered outputs; pulses drop while the clock is disqualified
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state           <= S_IDLE;
      byte_cnt        <= '0;
      get_sfd_pulse_o <= 1'b0;
      frame_active_o  <= 1'b0;
      rpl_crc_o       <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      byte_len_o      <= '0;
    end else if (rx_clk_en_i) begin
      state           <= state_nxt;
      byte_cnt        <= cnt_nxt;
      get_sfd_pulse_o <= sfd_nxt;
      frame_active_o  <= active_nxt;
      rpl_crc_o       <= rpl_nxt;
      frame_done_o    <= done_nxt;
      frame_err_o     <= err_nxt;
      byte_len_o      <= len_nxt;
    end else begin
      get_sfd_pulse_o <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;
    end
  end

`ifdef RX_RCST_STAT_EN
  // Saturating frame/embed/error statistics; clear wins over increment
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      rx_frm_cnt_o <= '0;
      rx_emb_cnt_o <= '0;
      rx_err_cnt_o <= '0;
    end else if (rx_clk_en_i) begin
      if (stat_clr_i) begin
        rx_frm_cnt_o <= '0;
        rx_emb_cnt_o <= '0;
        rx_err_cnt_o <= '0;
      end else begin
        if (done_nxt && (rx_frm_cnt_o != '1)) rx_frm_cnt_o <= rx_frm_cnt_o + 32'd1;
        if (done_nxt && rpl_nxt && (rx_emb_cnt_o != '1)) rx_emb_cnt_o <= rx_emb_cnt_o + 32'd1;
        if (err_nxt && (rx_err_cnt_o != '1)) rx_err_cnt_o <= rx_err_cnt_o + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not present in this build.
`endif

endmodule

// File: tb/tb_rx_rcst_ctrl.sv
// Directed bench for rx_rcst_ctrl; statistics checks run when RX_RCST_STAT_EN is defined.
module tb_rx_rcst_ctrl;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] ST0_W  = 64'hD5555555555555FB;
  localparam logic [63:0] ST4_W  = 64'h555555FB07070707;
  localparam logic [63:0] SFD_W  = 64'hAABBCCDDD5555555;
  localparam logic [63:0] DAT_W  = 64'h1122334455667788;
  localparam logic [63:0] T0_W   = 64'h07070707070707FD;
  localparam logic [63:0] T1_W   = 64'h070707070707FDAA;
  localparam logic [63:0] T4_W   = 64'h070707FDAABBCCDD;
  localparam logic [63:0] ERR_W  = 64'h1122334455FE7788;
  localparam logic [63:0] TS_W   = 64'h555555FB07FDBBAA;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_clk_en;
  logic [31:0] tsu_cfg;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        ptp_info_vld;
  logic        is_ptp_message;
  logic [3:0]  ptp_msg_type;
  logic        get_sfd_pulse, frame_active, rpl_crc, frame_done, frame_err;
  logic [13:0] byte_len;
`ifdef RX_RCST_STAT_EN
  logic        stat_clr;
  logic [31:0] rx_frm_cnt, rx_emb_cnt;
  logic [15:0] rx_err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int p_sfd, p_done, p_err;

  always #5 rx_clk = ~rx_clk;

  rx_rcst_ctrl dut (
    .rx_clk            (rx_clk),
    .rx_rst            (rx_rst),
    .rx_clk_en_i       (rx_clk_en),
    .tsu_cfg_i         (tsu_cfg),
    .rxd_i             (rxd),
    .rxc_i             (rxc),
    .ptp_info_vld_i    (ptp_info_vld),
    .is_ptp_message_i  (is_ptp_message),
    .ptp_messageType_i (ptp_msg_type),
    .get_sfd_pulse_o   (get_sfd_pulse),
    .frame_active_o    (frame_active),
    .rpl_crc_o         (rpl_crc),
    .frame_done_o      (frame_done),
    .frame_err_o       (frame_err),
    .byte_len_o        (byte_len)
`ifdef RX_RCST_STAT_EN
    ,
    .stat_clr_i        (stat_clr),
    .rx_frm_cnt_o      (rx_frm_cnt),
    .rx_emb_cnt_o      (rx_emb_cnt),
    .rx_err_cnt_o      (rx_err_cnt)
`endif
  );

  // Apply one word for one clock, sample #1 after the edge, tally pulses
  task automatic cyc(input logic [63:0] d, input logic [7:0] c,
                     input logic en = 1'b1, input logic vld = 1'b0);
    rxd = d; rxc = c; rx_clk_en = en; ptp_info_vld = vld;
    @(posedge rx_clk); #1;
    p_sfd  += int'(get_sfd_pulse);
    p_done += int'(frame_done);
    p_err  += int'(frame_err);
    ptp_info_vld = 1'b0;
    rx_clk_en = 1'b1;
  endtask

  task automatic clr_pulses();
    p_sfd = 0; p_done = 0; p_err = 0;
  endtask

  // Lane-0 framed packet: start word, ndata data words, terminate word
  task automatic frame0(input int ndata, input logic [63:0] tw, input logic [7:0] tc);
    cyc(ST0_W, 8'h01);
    for (int i = 0; i < ndata; i++) cyc(DAT_W, 8'h00);
    cyc(tw, tc);
  endtask

  task automatic test_reset();
    rx_rst = 1'b1; rx_clk_en = 1'b1; tsu_cfg = '0; rxd = IDLE_W; rxc = 8'hFF;
    ptp_info_vld = 1'b0; is_ptp_message = 1'b0; ptp_msg_type = '0;
`ifdef RX_RCST_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge rx_clk);
    #1 rx_rst = 1'b0;
    n_checks++; if ({get_sfd_pulse, frame_active, rpl_crc, frame_done, frame_err, byte_len} !== 19'd0)
      $display("FAIL reset_outputs: got %h exp 0", {get_sfd_pulse, frame_active, rpl_crc, frame_done, frame_err, byte_len}); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_lane0();
    clr_pulses();
    cyc(ST0_W, 8'h01);
    n_checks++; if (get_sfd_pulse !== 1'b1) $display("FAIL l0_sfd: got %b exp 1", get_sfd_pulse); else n_pass++;
    n_checks++; if (frame_active !== 1'b1) $display("FAIL l0_active: got %b exp 1", frame_active); else n_pass++;
    for (int i = 0; i < 8; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    n_checks++; if (frame_done !== 1'b1) $display("FAIL l0_done: got %b exp 1", frame_done); else n_pass++;
    n_checks++; if (byte_len !== 14'd68) $display("FAIL l0_len: got %0d exp 68", byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
    n_checks++; if (frame_active !== 1'b0) $display("FAIL l0_active_end: got %b exp 0", frame_active); else n_pass++;
    n_checks++; if ({p_sfd, p_done, p_err} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL l0_pulses: got sfd=%0d done=%0d err=%0d exp 1/1/0", p_sfd, p_done, p_err); else n_pass++;
  endtask

  task automatic test_lane4();
    clr_pulses();
    cyc(ST4_W, 8'h1F);
    n_checks++; if (get_sfd_pulse !== 1'b0) $display("FAIL l4_no_sfd_on_start: got %b exp 0", get_sfd_pulse); else n_pass++;
    cyc(SFD_W, 8'h00);
    n_checks++; if (get_sfd_pulse !== 1'b1) $display("FAIL l4_sfd: got %b exp 1", get_sfd_pulse); else n_pass++;
    for (int i = 0; i < 7; i++) cyc(DAT_W, 8'h00);
    cyc(T0_W, 8'hFF);
    n_checks++; if ({frame_err, frame_done} !== 2'b10) $display("FAIL l4_runt: got err/done=%b exp 10", {frame_err, frame_done}); else n_pass++;
    n_checks++; if (byte_len !== 14'd60) $display("FAIL l4_len: got %0d exp 60", byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
    clr_pulses();
    cyc(ST4_W, 8'h1F);
    cyc(DAT_W, 8'h00);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL pre4_bad_sfd: got %b exp 1", frame_err); else n_pass++;
    n_checks++; if (p_sfd !== 0) $display("FAIL pre4_bad_sfd_pulse: got %0d exp 0", p_sfd); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_embed();
    tsu_cfg = 32'h0000_0020; is_ptp_message = 1'b1; ptp_msg_type = 4'd0;
    cyc(IDLE_W, 8'hFF, 1'b1, 1'b1);
    n_checks++; if (rpl_crc !== 1'b0) $display("FAIL emb_vld_idle_ignored: got %b exp 0", rpl_crc); else n_pass++;
    cyc(ST0_W, 8'h01);
    cyc(DAT_W, 8'h00, 1'b1, 1'b1);
    n_checks++; if (rpl_crc !== 1'b1) $display("FAIL emb_set: got %b exp 1", rpl_crc); else n_pass++;
    for (int i = 0; i < 7; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    cyc(IDLE_W, 8'hFF);
    n_checks++; if (rpl_crc !== 1'b1) $display("FAIL emb_hold_after_term: got %b exp 1", rpl_crc); else n_pass++;
    ptp_msg_type = 4'd8;
    cyc(ST0_W, 8'h01);
    n_checks++; if (rpl_crc !== 1'b0) $display("FAIL emb_clr_on_sfd: got %b exp 0", rpl_crc); else n_pass++;
    cyc(DAT_W, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    n_checks++; if (rpl_crc !== 1'b0) $display("FAIL emb_type8: got %b exp 0", rpl_crc); else n_pass++;
    cyc(IDLE_W, 8'hFF);
    ptp_msg_type = 4'd0;
  endtask

  task automatic test_error_drain();
    cyc(ST0_W, 8'h01);
    cyc(DAT_W, 8'h00, 1'b1, 1'b1);
    cyc(ERR_W, 8'h04);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL err_pulse: got %b exp 1", frame_err); else n_pass++;
    n_checks++; if (rpl_crc !== 1'b0) $display("FAIL err_rpl_clr: got %b exp 0", rpl_crc); else n_pass++;
    clr_pulses();
    cyc(DAT_W, 8'h00);
    cyc(ST0_W, 8'h01);
    cyc(T0_W, 8'hFF);
    n_checks++; if ({p_sfd, p_done, p_err} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL drain_quiet: got sfd=%0d done=%0d err=%0d exp 0/0/0", p_sfd, p_done, p_err); else n_pass++;
    clr_pulses();
    frame0(8, T4_W, 8'hF0);
    n_checks++; if ({p_sfd, p_done} !== {32'd1, 32'd1}) $display("FAIL after_drain: got sfd=%0d done=%0d exp 1/1", p_sfd, p_done); else n_pass++;
    n_checks++; if (byte_len !== 14'd68) $display("FAIL after_drain_len: got %0d exp 68", byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_clk_en();
    clr_pulses();
    cyc(ST0_W, 8'h01);
    cyc(ST0_W, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(DAT_W, 8'h00);
      cyc(DAT_W, 8'h00, 1'b0);
    end
    cyc(T4_W, 8'hF0);
    cyc(T4_W, 8'hF0, 1'b0);
    n_checks++; if ({p_sfd, p_done, p_err} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL clken_pulses: got sfd=%0d done=%0d err=%0d exp 1/1/0", p_sfd, p_done, p_err); else n_pass++;
    n_checks++; if (byte_len !== 14'd68) $display("FAIL clken_len: got %0d exp 68", byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_reset_mid();
    cyc(ST0_W, 8'h01);
    cyc(DAT_W, 8'h00, 1'b1, 1'b1);
    cyc(DAT_W, 8'h00);
    rx_rst = 1'b1;
    #1;
    n_checks++; if ({get_sfd_pulse, frame_active, rpl_crc, frame_done, frame_err, byte_len} !== 19'd0)
      $display("FAIL rst_mid_outputs: got %h exp 0", {get_sfd_pulse, frame_active, rpl_crc, frame_done, frame_err, byte_len}); else n_pass++;
    @(posedge rx_clk); #1 rx_rst = 1'b0;
    clr_pulses();
    for (int i = 0; i < 5; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    n_checks++; if ({p_sfd, p_done, p_err} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL rst_mid_ignored: got sfd=%0d done=%0d err=%0d exp 0/0/0", p_sfd, p_done, p_err); else n_pass++;
    frame0(8, T4_W, 8'hF0);
    n_checks++; if ({frame_done, byte_len} !== {1'b1, 14'd68}) $display("FAIL rst_mid_next: got done=%b len=%0d exp 1/68", frame_done, byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_back_to_back();
    clr_pulses();
    cyc(ST0_W, 8'h01);
    for (int i = 0; i < 8; i++) cyc(DAT_W, 8'h00);
    cyc(TS_W, 8'h1C);
    n_checks++; if ({frame_done, byte_len} !== {1'b1, 14'd66}) $display("FAIL b2b_first: got done=%b len=%0d exp 1/66", frame_done, byte_len); else n_pass++;
    cyc(SFD_W, 8'h00);
    n_checks++; if (get_sfd_pulse !== 1'b1) $display("FAIL b2b_sfd: got %b exp 1", get_sfd_pulse); else n_pass++;
    for (int i = 0; i < 7; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    n_checks++; if ({frame_done, frame_err, byte_len} !== {2'b10, 14'd64}) $display("FAIL b2b_min64: got done/err=%b%b len=%0d exp 10/64", frame_done, frame_err, byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
    cyc(ST0_W, 8'h01);
    cyc(DAT_W, 8'h00);
    cyc(ST0_W, 8'h01);
    n_checks++; if ({frame_err, get_sfd_pulse} !== 2'b11) $display("FAIL abort_restart: got err/sfd=%b exp 11", {frame_err, get_sfd_pulse}); else n_pass++;
    for (int i = 0; i < 8; i++) cyc(DAT_W, 8'h00);
    cyc(T0_W, 8'hFF);
    n_checks++; if ({frame_done, byte_len} !== {1'b1, 14'd64}) $display("FAIL abort_new_frame: got done=%b len=%0d exp 1/64", frame_done, byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

  task automatic test_oversize();
    frame0(192, T0_W, 8'hFF);
    n_checks++; if ({frame_done, frame_err, byte_len} !== {2'b10, 14'd1536}) $display("FAIL max_ok: got done/err=%b%b len=%0d exp 10/1536", frame_done, frame_err, byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
    frame0(192, T1_W, 8'hFE);
    n_checks++; if ({frame_done, frame_err, byte_len} !== {2'b01, 14'd1537}) $display("FAIL max_over: got done/err=%b%b len=%0d exp 01/1537", frame_done, frame_err, byte_len); else n_pass++;
    cyc(IDLE_W, 8'hFF);
  endtask

`ifdef RX_RCST_STAT_EN
  task automatic test_stats();
    stat_clr = 1'b1; cyc(IDLE_W, 8'hFF); stat_clr = 1'b0;
    tsu_cfg = 32'h0000_0020; is_ptp_message = 1'b1; ptp_msg_type = 4'd0;
    cyc(ST0_W, 8'h01);
    cyc(DAT_W, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(DAT_W, 8'h00);
    cyc(T4_W, 8'hF0);
    cyc(IDLE_W, 8'hFF);
    frame0(8, T4_W, 8'hF0); cyc(IDLE_W, 8'hFF);
    frame0(8, T0_W, 8'hFF); cyc(IDLE_W, 8'hFF);
    frame0(7, T0_W, 8'hFF); cyc(IDLE_W, 8'hFF);
    n_checks++; if ({rx_frm_cnt, rx_emb_cnt, rx_err_cnt} !== {32'd3, 32'd1, 16'd1})
      $display("FAIL stat_counts: got %0d/%0d/%0d exp 3/1/1", rx_frm_cnt, rx_emb_cnt, rx_err_cnt); else n_pass++;
    stat_clr = 1'b1; cyc(IDLE_W, 8'hFF); stat_clr = 1'b0;
    n_checks++; if ({rx_frm_cnt, rx_emb_cnt, rx_err_cnt} !== 80'd0)
      $display("FAIL stat_clear: got %0d/%0d/%0d exp 0/0/0", rx_frm_cnt, rx_emb_cnt, rx_err_cnt); else n_pass++;
  endtask
`endif

  initial begin
    clr_pulses();
    test_reset();
    test_lane0();
    test_lane4();
    test_embed();
    test_error_drain();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    test_oversize();
`ifdef RX_RCST_STAT_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_rcst_ctrl.md
# rx_rcst_ctrl

Frame sequencer for the receive-side frame-reconstruct datapath. Tracks XGMII frame boundaries on the 64-bit receive stream and produces the start-of-frame (SFD) pulse consumed by the PTP parser. Latches a per-frame decision on whether the ingress timestamp is embedded, and drives the CRC-replace flag to the CRC module. Reports frame completion, byte length and framing errors to the TSU.

## Interface
Parameters:
- MAX_BYTES, 1536: oversize threshold in bytes, counted from the first byte after SFD through FCS.
- MIN_BYTES, 64: runt threshold in bytes.

Ports:
- rx_clk  in  1  receive clock.
- rx_rst  in  1  asynchronous, active-high reset.
- rx_clk_en_i  in  1  clock qualifier; all state updates are gated by it.
- tsu_cfg_i  in  32  configuration; bit 5 = emb_ingressTime_en.
- rxd_i  in  64  XGMII data; lane n = bits [8n+7:8n].
- rxc_i  in  8  XGMII control; bit n qualifies lane n.
- ptp_info_vld_i  in  1  one-cycle pulse: the classifier result for the current frame is valid.
- is_ptp_message_i  in  1  classifier: frame is PTP.
- ptp_messageType_i  in  4  classifier: PTP messageType.
- get_sfd_pulse_o  out  1  one-cycle pulse on the word carrying SFD (0xD5).
- frame_active_o  out  1  high from the SFD word through the terminate word.
- rpl_crc_o  out  1  CRC-replace flag to the CRC module.
- frame_done_o  out  1  one-cycle pulse on clean frame end.
- frame_err_o  out  1  one-cycle pulse on a framing error.
- byte_len_o  out  14  byte count of the last finished frame; valid with frame_done_o or frame_err_o.

## Operation
Control characters: Start = 0xFB, Terminate = 0xFD, Error = 0xFE, Idle = 0x07. A character counts only when its rxc bit is 1.

FSM states: IDLE, PRE4, DATA, DRAIN.
- IDLE, lane 0 = Start: move to DATA. Assert get_sfd_pulse_o (SFD is in lane 7). byte_cnt := 0.
- IDLE, lane 4 = Start: move to PRE4.
- PRE4, next word has lane 3 = 0xD5 with rxc = 0: move to DATA. Assert get_sfd_pulse_o. byte_cnt := 4.
- PRE4, any other word: move to IDLE and pulse frame_err_o.
- DATA, word with rxc = 0x00: byte_cnt += 8. byte_cnt saturates at 2^14-1.
- DATA, first rxc bit set in lane k holds Terminate: byte_cnt += k, move to IDLE, then apply the end checks.
  - byte_cnt < MIN_BYTES or > MAX_BYTES: pulse frame_err_o.
  - otherwise: pulse frame_done_o.
  - byte_len_o is loaded with the final count in either case.
- DATA, any other control character (Error, Idle, Start) in any lane: pulse frame_err_o and move to DRAIN.
  - Exception: Start in lane 0 or lane 4 is treated as an abort followed by a new frame. Pulse frame_err_o and re-enter the lane-0 or lane-4 start path in the same cycle.
- DRAIN: stay until a word contains Terminate or is all Idle, then move to IDLE. No pulses are generated in DRAIN.

Embed decision: embed = tsu_cfg_i[5] & is_ptp_message_i & ~ptp_messageType_i[3], sampled only when ptp_info_vld_i = 1 in DATA.

rpl_crc_o behaviour, in priority order:
- Cleared on get_sfd_pulse_o.
- Cleared on any frame_err_o. The CRC of an errored frame is never regenerated.
- Set on ptp_info_vld_i with embed = 1.
- Otherwise holds its value. It stays high through the terminate word and the following word, so the delayed CRC path can still use it, and is cleared on the next SFD.

ptp_info_vld_i outside DATA is ignored. A second ptp_info_vld_i in the same frame may set rpl_crc_o but never clear it.

## Timing
- All outputs are registered. A response appears on the clock edge after the rxd_i/rxc_i word is sampled, so latency is 1 enabled cycle.
- When rx_clk_en_i = 0, the FSM, counters and outputs hold their values, and pulses do not repeat.
- Reset values: FSM in IDLE, byte_cnt 0, and every output 0, including byte_len_o.
- Reset mid-frame forces IDLE immediately. The remainder of that frame is ignored until the next Start.
- Same-word Terminate and Start (Terminate in lanes 0–3, Start in lane 4): close the current frame, then enter PRE4 on the same cycle.

## Configuration
- RX_RCST_STAT_EN defined: the block adds statistics outputs rx_frm_cnt_o (32 bits), rx_emb_cnt_o (32 bits) and rx_err_cnt_o (16 bits), plus the input stat_clr_i.
  - rx_frm_cnt_o increments on frame_done_o.
  - rx_emb_cnt_o increments on frame_done_o when rpl_crc_o = 1.
  - rx_err_cnt_o increments on frame_err_o.
  - All three counters saturate, reset to 0, and clear synchronously on stat_clr_i. If stat_clr_i coincides with an increment, the clear wins.
- RX_RCST_STAT_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Lane-0 Start, 8 data words, Terminate in lane 4 → get_sfd_pulse_o 1 cycle after the start word; frame_done_o pulse; byte_len_o = 68.
- Lane-4 Start, then SFD word, 7 data words, Terminate in lane 0 → SFD pulse on the second word; byte_len_o = 60 (<64), so frame_err_o pulses and frame_done_o does not.
- PTP Sync frame (type 0) with cfg bit 5 = 1 and ptp_info_vld_i pulsed → rpl_crc_o = 1 until the next SFD. Repeat with type 8 → rpl_crc_o stays 0.
- Error character mid-frame after rpl_crc_o is set → frame_err_o pulses; rpl_crc_o = 0; FSM in DRAIN until Terminate; the next frame is detected normally.
- rx_clk_en_i toggling 1/0 every cycle during a 68-byte frame → same pulse count and byte_len_o = 68. rx_rst asserted mid-frame → all outputs 0 and FSM in IDLE.
- With RX_RCST_STAT_EN defined: 3 good frames (1 embedded) and 1 errored frame → rx_frm_cnt_o = 3, rx_emb_cnt_o = 1, rx_err_cnt_o = 1; stat_clr_i → all 0.
